minmax_window_ctl: RTL and testbench
====================================

# minmax_window_ctl

Window sequencer for the pipelined min/max tracker tree. It issues the tracker's restart pulse at the start of each measurement window, counts the window length, and captures the tree's min/max outputs once the last window sample has drained through the tree. It then presents each window's result on a one-entry valid/ready output register. It sits between the tracker and the register/readout fabric, in either single-shot or back-to-back continuous mode.

## Interface
- DW, 16: sample/result width, signed.
- LW, 16: window-length counter width.
- L, 2: tree depth, equal to ceil(log2 lanes) of the attached tracker; 0 is allowed for a 1-lane tracker.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock, with all logic on clk and reset synchronous and active-high.
- start  in  1  one-cycle pulse that begins acquisition; ignored while busy.
- cont  in  1  continuous mode; sampled with start.
- stop  in  1  one-cycle pulse; continuous mode ends after the current window.
- win_len  in  LW  window length in cycles; sampled at every window start; 0 is treated as 1.
- mm_reset  out  1  restart pulse to the tracker.
- mm_min  in  DW  tracker min output, signed.
- mm_max  in  DW  tracker max output, signed.
- busy  out  1  high when the state is not IDLE or capture tokens are in flight.
- res_valid  out  1  result register full.
- res_ready  in  1  consumer accept.
- res_min  out  DW  captured min.
- res_max  out  DW  captured max.
- res_seq  out  8  window sequence number, wrapping at 255->0.
- overrun  out  1  sticky flag; set when a capture finds res_valid high and res_ready low.

## Operation
- States: IDLE, RUN.
- IDLE, start=1: latch cont into mode_c; assert mm_reset this cycle; load cnt=max(win_len,1)-1; go to RUN.
- RUN with cnt!=0: decrement cnt.
- RUN with cnt==0, which is the last window cycle: inject a capture token into an L-stage token shift register.
  - If mode_c=1 and no stop is pending, assert mm_reset in the next cycle, reload cnt from win_len, and stay in RUN. Windows are back-to-back with no gap.
  - Otherwise, go to IDLE.
- A stop pulse sets a pending flag, which clears on entry to IDLE. A stop pulse in IDLE, or in single-shot mode, has no effect.
- Capture: when a token exits the shift register, sample mm_min/mm_max into the capture path. With L=0 this happens on the token cycle itself.
- Capture with res_valid=0, or with res_valid=1 and res_ready=1 in the same cycle:
  - load res_min, res_max, res_seq=seq; seq++.
  - set res_valid.
- Capture with res_valid=1 and res_ready=0: drop the new result, set overrun, and still increment seq, so the consumer sees the gap.
- res_valid=1 and res_ready=1 with no capture: clear res_valid.
- start while busy is ignored, including during token drain after RUN.
- Reset state:
  - state=IDLE, tokens cleared, mm_reset=0, busy=0.
  - res_valid=0, res_min=0, res_max=0, res_seq=0, seq=0, overrun=0.
- Reset in the middle of a window or drain abandons all in-flight results.

## Timing
- Window k starts at cycle c_k, where mm_reset=1. Its last cycle is c_k+N_k-1 and c_{k+1}=c_k+N_k.
- Capture occurs at cycle c_k+N_k+L, which is when the tracker root reflects the full window.
- res_valid rises at c_k+N_k+L+1.
- Single-shot: busy falls at c_k+N_k+L+1.
- mm_reset is registered and high for exactly one cycle per window.
- In continuous mode the mm_reset pulses are spaced exactly N cycles apart. With win_len=1 mm_reset is held high continuously, one capture per cycle.
- res_* hold stable while res_valid=1 and res_ready=0.

## Configuration
- MINMAX_SPAN_EN defined:
  - adds output res_span (DW+1 bits, unsigned) = res_max - res_min, computed at full width and registered alongside res_min/res_max, with identical valid timing.
  - reset value of res_span is 0.
- MINMAX_SPAN_EN undefined: res_span and the subtractor are absent from the port list and the logic.

## Test plan
- Single-shot, L=2, win_len=8, ramp input -3..4 on one lane:
  - mm_reset is high for 1 cycle.
  - res_valid rises 11 cycles after start is sampled.
  - min=-3, max=4, seq=0, busy then drops.
- Continuous, win_len=5, res_ready=1, stop after the 3rd window start:
  - exactly 3 results, seq 0,1,2.
  - mm_reset pulses spaced 5 cycles apart.
  - no overrun.
- Continuous, win_len=1: a capture every cycle, with res_seq incrementing by 1 per cycle while res_ready=1.
- res_ready=0 across two windows:
  - first result is held.
  - overrun=1.
  - the next accepted result shows res_seq skipping by 2.
- reset asserted mid-RUN and again during token drain:
  - all outputs return to their reset values next cycle.
  - no stale res_valid.
  - start one cycle later behaves as a fresh single-shot.
- MINMAX_SPAN_EN, window containing -32768 and 32767 (DW=16): res_span=65535.

Source files
------------

// File: rtl/minmax_window_ctl_if.sv
// -----------------------------------------------------------------------------
// minmax_window_ctl_if
//
// Result bus between the min/max window sequencer and the readout fabric.
// It carries a one-entry valid/ready register holding one window's result.
//
//   res_valid  master->slave  the result register is full
//   res_ready  slave->master  the consumer accepts the result this cycle
//   res_min    master->slave  captured window minimum, signed DW bits
//   res_max    master->slave  captured window maximum, signed DW bits
//   res_seq    master->slave  window sequence number, wraps 255->0
//   res_span   master->slave  res_max - res_min, unsigned DW+1 bits
//                             (present only when MINMAX_SPAN_EN is defined)
//
// Optional feature macro: MINMAX_SPAN_EN
// -----------------------------------------------------------------------------
interface minmax_window_ctl_if #(
    parameter int DW = 16
);
    logic                 res_valid;
    logic                 res_ready;
    logic signed [DW-1:0] res_min;
    logic signed [DW-1:0] res_max;
    logic [7:0]           res_seq;
`ifdef MINMAX_SPAN_EN
    logic [DW:0]          res_span;

    modport master (
        output res_valid, res_min, res_max, res_seq, res_span,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_min, res_max, res_seq, res_span,
        output res_ready
    );
`else
    modport master (
        output res_valid, res_min, res_max, res_seq,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_min, res_max, res_seq,
        output res_ready
    );
`endif
endinterface

// File: rtl/minmax_window_ctl.sv
// -----------------------------------------------------------------------------
// minmax_window_ctl
//
// Window sequencer for a pipelined min/max tracker tree. It pulses the
// tracker's restart at the start of every measurement window and counts the
// window length. Once the last sample of the window has drained through the
// tree, it captures the tree's min/max into a one-entry valid/ready result
// register. It runs single-shot or back-to-back continuous.
//
// Parameters
//   DW  sample/result width (signed)
//   LW  window-length counter width
//   L   tracker tree depth, ceil(log2 lanes); 0 for a 1-lane tracker
//
// Ports
//   clk       system clock
//   reset     synchronous, active-high reset
//   start     one-cycle pulse that begins acquisition; ignored while busy
//   cont      continuous mode, sampled together with start
//   stop      one-cycle pulse; continuous mode ends after the current window
//   win_len   window length in cycles, sampled at every window start (0 -> 1)
//   mm_reset  registered restart pulse to the tracker, one per window
//   mm_min    tracker min output (signed)
//   mm_max    tracker max output (signed)
//   busy      sequencer running or capture tokens still in flight
//   overrun   sticky: a capture found the result register full and unread
//   res       result bus (minmax_window_ctl_if.master)
//
// Optional feature macro: MINMAX_SPAN_EN (adds res_span = res_max - res_min)
// -----------------------------------------------------------------------------
module minmax_window_ctl #(
    parameter int DW = 16,
    parameter int LW = 16,
    parameter int L  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 cont,
    input  logic                 stop,
    input  logic [LW-1:0]        win_len,
    output logic                 mm_reset,
    input  logic signed [DW-1:0] mm_min,
    input  logic signed [DW-1:0] mm_max,
    output logic                 busy,
    output logic                 overrun,
    minmax_window_ctl_if.master  res
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state;
    logic          mode_c;     // continuous mode latched at start
    logic          stop_pend;  // stop seen during a continuous run
    logic [LW-1:0] cnt;        // cycles left in the current window
    logic [7:0]    seq;        // sequence number of the next captured window

    // Capture token pipeline. Stage 0 lines up with the tracker's
    // accumulator register and stages 1..L with the tree levels, so a token
    // leaves stage L in the cycle the tree root shows the complete window.
    logic [L:0]    tok;

    logic [LW-1:0] load_cnt;
    logic          last_cycle;
    logic          stop_seen;
    logic          capture;

    // A window length of 0 is run as a 1-cycle window.
    assign load_cnt   = (win_len == '0) ? '0 : win_len - LW'(1);
    assign last_cycle = (state == RUN) && (cnt == '0);
    // A stop arriving in the last window cycle itself also ends the run.
    assign stop_seen  = stop_pend || stop;
    assign capture    = tok[L];
    assign busy       = (state != IDLE) || (tok != '0);

    // Sequencer FSM with registered tracker restart.
    // NOTE: sequential state is written only with non-blocking assignments,
    // so every flop samples values from before the clock edge regardless of
    // statement order.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous: it is just the highest-priority branch
        // of the clocked block, and it takes effect on the next edge.
        if (reset) begin
            state     <= IDLE;
            mode_c    <= 1'b0;
            stop_pend <= 1'b0;
            cnt       <= '0;
            mm_reset  <= 1'b0;
            tok       <= '0;
        end else begin
            tok      <= (tok << 1) | (L + 1)'(last_cycle);
            mm_reset <= 1'b0;

            case (state)
                IDLE: begin
                    // Starts during token drain are ignored, as they are in RUN.
                    if (start && (tok == '0)) begin
                        mode_c    <= cont;
                        stop_pend <= 1'b0;
                        mm_reset  <= 1'b1;
                        cnt       <= load_cnt;
                        state     <= RUN;
                    end
                end

                RUN: begin
                    if (stop && mode_c) begin
                        stop_pend <= 1'b1;
                    end

                    if (cnt != '0) begin
                        cnt <= cnt - LW'(1);
                    end else if (mode_c && !stop_seen) begin
                        // Next window begins in the very next cycle: no gap.
                        mm_reset <= 1'b1;
                        cnt      <= load_cnt;
                    end else begin
                        stop_pend <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // One-entry result register. A capture that finds the register full and
    // not being drained is dropped, but seq still advances so the consumer
    // can see the gap in res_seq.
    always_ff @(posedge clk) begin
        if (reset) begin
            res.res_valid <= 1'b0;
            res.res_min   <= '0;
            res.res_max   <= '0;
            res.res_seq   <= '0;
`ifdef MINMAX_SPAN_EN
            res.res_span  <= '0;
`endif
            seq           <= '0;
            overrun       <= 1'b0;
        end else if (capture) begin
            if (!res.res_valid || res.res_ready) begin
                res.res_valid <= 1'b1;
                res.res_min   <= mm_min;
                res.res_max   <= mm_max;
                res.res_seq   <= seq;
`ifdef MINMAX_SPAN_EN
                // Sign-extend both sides so the difference cannot wrap.
                res.res_span  <= {mm_max[DW-1], mm_max} - {mm_min[DW-1], mm_min};
`endif
            end else begin
                overrun <= 1'b1;
            end
            seq <= seq + 8'd1;
        end else if (res.res_valid && res.res_ready) begin
            res.res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_minmax_window_ctl.sv
// -----------------------------------------------------------------------------
// tb_minmax_window_ctl
//
// Directed self-checking bench for minmax_window_ctl with L=2. A behavioural
// one-lane tracker (restartable min/max accumulator followed by two pipeline
// stages) supplies mm_min/mm_max. Inputs change and outputs are sampled on
// the falling clock edge.
// -----------------------------------------------------------------------------
module tb_minmax_window_ctl;

    localparam int DW = 16;
    localparam int LW = 16;
    localparam int L  = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 cont;
    logic                 stop;
    logic [LW-1:0]        win_len;
    logic                 mm_reset;
    logic signed [DW-1:0] mm_min;
    logic signed [DW-1:0] mm_max;
    logic                 busy;
    logic                 overrun;

    logic signed [DW-1:0] sample;
    logic signed [DW-1:0] acc_min, acc_max, p0_min, p0_max;

    int cyc    = 0;
    int ncheck = 0;
    int nfail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    minmax_window_ctl_if #(.DW(DW)) res_if ();

    minmax_window_ctl #(.DW(DW), .LW(LW), .L(L)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .cont     (cont),
        .stop     (stop),
        .win_len  (win_len),
        .mm_reset (mm_reset),
        .mm_min   (mm_min),
        .mm_max   (mm_max),
        .busy     (busy),
        .overrun  (overrun),
        .res      (res_if)
    );

    // Tracker model: the root shows a window's full min/max L+1 cycles after
    // the window's last sample cycle.
    always @(posedge clk) begin
        if (mm_reset) begin
            acc_min <= sample;
            acc_max <= sample;
        end else begin
            acc_min <= (sample < acc_min) ? sample : acc_min;
            acc_max <= (sample > acc_max) ? sample : acc_max;
        end
        p0_min <= acc_min;
        p0_max <= acc_max;
        mm_min <= p0_min;
        mm_max <= p0_max;
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic signed [DW-1:0] ovr_smp(int i);
        case (i)
            0: return 16'sd5;   1: return -16'sd9;  2: return 16'sd12;  3: return 16'sd0;
            4: return 16'sd1;   5: return 16'sd2;   6: return 16'sd3;   7: return 16'sd4;
            8: return -16'sd1;  9: return -16'sd2;  10: return -16'sd3; 11: return -16'sd4;
            default: return 16'sd0;
        endcase
    endfunction

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; cont = 1'b0; stop = 1'b0;
        win_len = '0; sample = '0; res_if.res_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        ncheck++;
        if ({mm_reset, busy, res_if.res_valid, overrun} !== 4'b0000) begin
            nfail++;
            $display("FAIL reset_flags: got %b expected 0000", {mm_reset, busy, res_if.res_valid, overrun});
        end
        ncheck++;
        if ({res_if.res_min, res_if.res_max, res_if.res_seq} !== 40'd0) begin
            nfail++;
            $display("FAIL reset_data: min %0d max %0d seq %0d expected all 0", res_if.res_min, res_if.res_max, res_if.res_seq);
        end
`ifdef MINMAX_SPAN_EN
        ncheck++;
        if (res_if.res_span !== 17'd0) begin
            nfail++;
            $display("FAIL reset_span: got %0d expected 0", res_if.res_span);
        end
`endif
        tick();
        ncheck++;
        if (busy !== 1'b0) begin
            nfail++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    // Single-shot, win_len=8, ramp -3..4; a start pulse during drain must be ignored.
    task automatic test_single_shot;
        int pulses;
        int rise;
        logic busy_at_rise;
        logic busy_at_cap;
        pulses = 0; rise = -1; busy_at_rise = 1'bx; busy_at_cap = 1'bx;
        do_reset();
        res_if.res_ready = 1'b0; cont = 1'b0; win_len = 16'd8;
        sample = 16'sd100; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sample = (i < 8) ? 16'(i - 3) : 16'sd100;
            start  = (i == 9);
            if (mm_reset) pulses++;
            if (i == 10) busy_at_cap = busy;
            if (rise < 0 && res_if.res_valid) begin
                rise = i;
                busy_at_rise = busy;
            end
            tick();
        end
        start = 1'b0;
        ncheck++;
        if (pulses !== 1) begin
            nfail++; $display("FAIL single_mm_reset_pulses: got %0d expected 1", pulses);
        end
        ncheck++;
        if (rise !== 11) begin
            nfail++; $display("FAIL single_valid_latency: got %0d expected 11", rise);
        end
        ncheck++;
        if (busy_at_cap !== 1'b1) begin
            nfail++; $display("FAIL single_busy_drain: got %b expected 1", busy_at_cap);
        end
        ncheck++;
        if (busy_at_rise !== 1'b0) begin
            nfail++; $display("FAIL single_busy_fall: got %b expected 0", busy_at_rise);
        end
        ncheck++;
        if (res_if.res_min !== -16'sd3 || res_if.res_max !== 16'sd4) begin
            nfail++; $display("FAIL single_minmax: got %0d/%0d expected -3/4", res_if.res_min, res_if.res_max);
        end
        ncheck++;
        if (res_if.res_seq !== 8'd0 || res_if.res_valid !== 1'b1) begin
            nfail++; $display("FAIL single_seq_held: seq %0d valid %b expected 0/1", res_if.res_seq, res_if.res_valid);
        end
        res_if.res_ready = 1'b1;
        tick();
        res_if.res_ready = 1'b0;
        ncheck++;
        if (res_if.res_valid !== 1'b0) begin
            nfail++; $display("FAIL single_accept_clear: got %b expected 0", res_if.res_valid);
        end
    endtask

    // Continuous, win_len=5, always ready, stop during the 3rd window.
    task automatic test_continuous;
        int rst_at[$];
        int seqs[$];
        int got;
        do_reset();
        res_if.res_ready = 1'b1; cont = 1'b1; win_len = 16'd5; start = 1'b1;
        tick();
        start = 1'b0; cont = 1'b0;
        for (int i = 0; i < 40; i++) begin
            sample = 16'(i);
            stop   = 1'b0;
            if (mm_reset) begin
                rst_at.push_back(i);
                if (rst_at.size() == 3) stop = 1'b1;
            end
            if (res_if.res_valid && res_if.res_ready) seqs.push_back(int'(res_if.res_seq));
            tick();
        end
        stop = 1'b0;
        ncheck++;
        if (rst_at.size() !== 3) begin
            nfail++; $display("FAIL cont_window_count: got %0d expected 3", rst_at.size());
        end
        for (int k = 1; k < 3; k++) begin
            got = (k < rst_at.size()) ? rst_at[k] - rst_at[k-1] : -1;
            ncheck++;
            if (got !== 5) begin
                nfail++; $display("FAIL cont_mm_reset_spacing[%0d]: got %0d expected 5", k, got);
            end
        end
        ncheck++;
        if (seqs.size() !== 3) begin
            nfail++; $display("FAIL cont_result_count: got %0d expected 3", seqs.size());
        end
        for (int k = 0; k < 3; k++) begin
            got = (k < seqs.size()) ? seqs[k] : -1;
            ncheck++;
            if (got !== k) begin
                nfail++; $display("FAIL cont_seq[%0d]: got %0d expected %0d", k, got, k);
            end
        end
        ncheck++;
        if (res_if.res_min !== 16'sd10 || res_if.res_max !== 16'sd14) begin
            nfail++; $display("FAIL cont_last_minmax: got %0d/%0d expected 10/14", res_if.res_min, res_if.res_max);
        end
        ncheck++;
        if (overrun !== 1'b0 || busy !== 1'b0) begin
            nfail++; $display("FAIL cont_end_state: overrun %b busy %b expected 0/0", overrun, busy);
        end
    endtask

    // Continuous, win_len=1: restart held high and one result per cycle.
    task automatic test_win_len_one;
        int waited;
        do_reset();
        res_if.res_ready = 1'b1; cont = 1'b1; win_len = 16'd1; start = 1'b1;
        tick();
        start = 1'b0; cont = 1'b0;
        for (int i = 0; i < 11; i++) begin
            sample = 16'(i * 3);
            ncheck++;
            if (mm_reset !== 1'b1) begin
                nfail++; $display("FAIL len1_mm_reset[%0d]: got %b expected 1", i, mm_reset);
            end
            if (i >= 4) begin
                ncheck++;
                if (res_if.res_valid !== 1'b1 || res_if.res_seq !== 8'(i - 4)) begin
                    nfail++;
                    $display("FAIL len1_seq[%0d]: valid %b seq %0d expected 1/%0d", i, res_if.res_valid, res_if.res_seq, i - 4);
                end
                ncheck++;
                if (res_if.res_min !== 16'((i - 4) * 3) || res_if.res_max !== 16'((i - 4) * 3)) begin
                    nfail++;
                    $display("FAIL len1_value[%0d]: got %0d/%0d expected %0d", i, res_if.res_min, res_if.res_max, (i - 4) * 3);
                end
            end
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        waited = 0;
        while (busy && waited < 20) begin
            tick();
            waited++;
        end
        ncheck++;
        if (busy !== 1'b0) begin
            nfail++; $display("FAIL len1_stop_timeout: busy %b after %0d cycles expected 0", busy, waited);
        end
        ncheck++;
        if (overrun !== 1'b0) begin
            nfail++; $display("FAIL len1_overrun: got %b expected 0", overrun);
        end
    endtask

    // Continuous, win_len=4, consumer stalled across the first two windows.
    task automatic test_overrun;
        do_reset();
        res_if.res_ready = 1'b0; cont = 1'b1; win_len = 16'd4; start = 1'b1;
        tick();
        start = 1'b0; cont = 1'b0;
        for (int i = 0; i < 22; i++) begin
            sample = ovr_smp(i);
            stop   = (i == 8);
            res_if.res_ready = (i == 12) || (i >= 16);
            if (i == 7) begin
                ncheck++;
                if (res_if.res_valid !== 1'b1 || res_if.res_min !== -16'sd9 || res_if.res_max !== 16'sd12 || res_if.res_seq !== 8'd0) begin
                    nfail++;
                    $display("FAIL ovr_first: valid %b min %0d max %0d seq %0d expected 1/-9/12/0",
                             res_if.res_valid, res_if.res_min, res_if.res_max, res_if.res_seq);
                end
                ncheck++;
                if (overrun !== 1'b0) begin
                    nfail++; $display("FAIL ovr_early: got %b expected 0", overrun);
                end
            end
            if (i == 8) begin
                ncheck++;
                if (mm_reset !== 1'b1) begin
                    nfail++; $display("FAIL ovr_third_start: got %b expected 1", mm_reset);
                end
            end
            if (i == 11) begin
                ncheck++;
                if (overrun !== 1'b1) begin
                    nfail++; $display("FAIL ovr_flag: got %b expected 1", overrun);
                end
                ncheck++;
                if (res_if.res_valid !== 1'b1 || res_if.res_seq !== 8'd0 || res_if.res_min !== -16'sd9 || res_if.res_max !== 16'sd12) begin
                    nfail++;
                    $display("FAIL ovr_held: valid %b min %0d max %0d seq %0d expected 1/-9/12/0",
                             res_if.res_valid, res_if.res_min, res_if.res_max, res_if.res_seq);
                end
            end
            if (i == 13) begin
                ncheck++;
                if (res_if.res_valid !== 1'b0) begin
                    nfail++; $display("FAIL ovr_accept_clear: got %b expected 0", res_if.res_valid);
                end
            end
            if (i == 15) begin
                ncheck++;
                if (res_if.res_valid !== 1'b1 || res_if.res_seq !== 8'd2 || res_if.res_min !== -16'sd4 || res_if.res_max !== -16'sd1) begin
                    nfail++;
                    $display("FAIL ovr_seq_gap: valid %b min %0d max %0d seq %0d expected 1/-4/-1/2",
                             res_if.res_valid, res_if.res_min, res_if.res_max, res_if.res_seq);
                end
            end
            tick();
        end
        stop = 1'b0;
        ncheck++;
        if (busy !== 1'b0 || overrun !== 1'b1) begin
            nfail++; $display("FAIL ovr_end: busy %b overrun %b expected 0/1", busy, overrun);
        end
    endtask

    // Reset mid-RUN and during token drain, then a fresh single-shot.
    task automatic test_reset_mid;
        int stale;
        int rise;
        stale = 0; rise = -1;
        res_if.res_ready = 1'b0; cont = 1'b0; win_len = 16'd8; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        ncheck++;
        if (busy !== 1'b1) begin
            nfail++; $display("FAIL mid_run_busy: got %b expected 1", busy);
        end
        do_reset();
        ncheck++;
        if ({mm_reset, busy, res_if.res_valid, overrun} !== 4'b0000) begin
            nfail++;
            $display("FAIL mid_run_flags: got %b expected 0000", {mm_reset, busy, res_if.res_valid, overrun});
        end
        ncheck++;
        if ({res_if.res_min, res_if.res_max, res_if.res_seq} !== 40'd0) begin
            nfail++;
            $display("FAIL mid_run_data: min %0d max %0d seq %0d expected all 0", res_if.res_min, res_if.res_max, res_if.res_seq);
        end
        for (int i = 0; i < 12; i++) begin
            if (res_if.res_valid || mm_reset) stale++;
            tick();
        end
        ncheck++;
        if (stale !== 0) begin
            nfail++; $display("FAIL mid_run_stale: got %0d active cycles expected 0", stale);
        end

        win_len = 16'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample = 16'(7 + i);
            tick();
        end
        ncheck++;
        if (busy !== 1'b1 || mm_reset !== 1'b0) begin
            nfail++; $display("FAIL drain_busy: busy %b mm_reset %b expected 1/0", busy, mm_reset);
        end
        do_reset();
        ncheck++;
        if (busy !== 1'b0 || res_if.res_valid !== 1'b0) begin
            nfail++; $display("FAIL drain_reset: busy %b valid %b expected 0/0", busy, res_if.res_valid);
        end

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: sample = -16'sd1;
                1: sample = 16'sd6;
                2: sample = 16'sd2;
                default: sample = 16'sd50;
            endcase
            if (rise < 0 && res_if.res_valid) rise = i;
            tick();
        end
        ncheck++;
        if (rise !== 6) begin
            nfail++; $display("FAIL fresh_latency: got %0d expected 6", rise);
        end
        ncheck++;
        if (res_if.res_min !== -16'sd1 || res_if.res_max !== 16'sd6 || res_if.res_seq !== 8'd0) begin
            nfail++;
            $display("FAIL fresh_result: min %0d max %0d seq %0d expected -1/6/0", res_if.res_min, res_if.res_max, res_if.res_seq);
        end
    endtask

`ifdef MINMAX_SPAN_EN
    // Full-range window: the span needs the extra bit.
    task automatic test_span;
        int rise;
        rise = -1;
        do_reset();
        res_if.res_ready = 1'b0; cont = 1'b0; win_len = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: sample = 16'sh8000;
                1: sample = 16'sh7fff;
                default: sample = 16'sd0;
            endcase
            if (rise < 0 && res_if.res_valid) rise = i;
            tick();
        end
        ncheck++;
        if (rise !== 5) begin
            nfail++; $display("FAIL span_latency: got %0d expected 5", rise);
        end
        ncheck++;
        if (res_if.res_span !== 17'd65535) begin
            nfail++; $display("FAIL span_value: got %0d expected 65535", res_if.res_span);
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_shot();
        test_continuous();
        test_win_len_one();
        test_overrun();
        test_reset_mid();
`ifdef MINMAX_SPAN_EN
        test_span();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
        $finish;
    end

endmodule
